// File: rtl/rom_fetch_pkg.sv
// rom_fetch_pkg: shared definitions for the program-ROM fetch unit.
//   ADDR_W / DATA_W : ROM address and word widths (256 x 16 program ROM).
//   fetch_state_e   : fetch controller states {IDLE, RUN, DRAIN}.
//   fetch_entry_t   : a fetched word tagged with the address it came from.
//   pc_inc()        : next sequential fetch address, wrapping at 2**ADDR_W.
package rom_fetch_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] data;
    } fetch_entry_t;

    // Sequential successor; natural overflow gives the 0xFF -> 0x00 wrap.
    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        return pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/rom_fetch_skid.sv
// rom_fetch_skid: 2-entry output FIFO for the fetch unit (built only when
// ROM_FETCH_SKID_EN is defined). Entry 0 is always the head, so the outputs
// come straight from flops.
//   clock, reset        : clock and synchronous active-high reset
//   flush               : discard all entries (count -> 0), overrides push
//   push, push_entry    : write one tagged word
//   pop                 : head consumed this cycle
//   head, head_valid    : current head entry and its valid flag
//   count               : current occupancy (0..2)
`ifdef ROM_FETCH_SKID_EN
module rom_fetch_skid
    import rom_fetch_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         head_valid,
    output logic [1:0]   count
);

    fetch_entry_t entry0_q, entry0_d;
    fetch_entry_t entry1_q, entry1_d;
    logic [1:0]   count_q, count_d;
    logic         valid_q, valid_d;
    logic [1:0]   count_after_pop_s;

    // Next-state: shift on pop, then write the push into the first free slot.
    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        if (pop && (count_q != 2'd0)) begin
            count_after_pop_s = count_q - 2'd1;
            entry0_d          = entry1_q;
        end else begin
            count_after_pop_s = count_q;
        end
        // The issue rule guarantees a push never lands on a full FIFO.
        if (push) begin
            if (count_after_pop_s == 2'd0) begin
                entry0_d = push_entry;
            end else begin
                entry1_d = push_entry;
            end
        end else begin
            entry1_d = entry1_d;
        end
        if (flush) begin
            count_d = 2'd0;
        end else begin
            count_d = count_after_pop_s + {1'b0, push};
        end
        valid_d = (count_d != 2'd0);
    end

    // FIFO storage and occupancy registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            entry0_q <= {$bits(fetch_entry_t){1'b0}};
            entry1_q <= {$bits(fetch_entry_t){1'b0}};
            count_q  <= 2'd0;
            valid_q  <= 1'b0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    assign head       = entry0_q;
    assign head_valid = valid_q;
    assign count      = count_q;

endmodule
`endif

// File: rtl/rom_fetch_unit.sv
// rom_fetch_unit: initiator for the 256x16 synchronous program ROM. Owns the
// fetch PC, absorbs the ROM's one-cycle read latency and presents each word
// with its address to the decoder over valid/ready.
// Build option: define ROM_FETCH_SKID_EN for a 2-entry skid FIFO on the output
// (1 word/cycle); otherwise a single output register (1 word / 2 cycles).
// Ports:
//   clock, reset               : clock (also the ROM clock), sync active-high reset
//   start, start_addr          : in IDLE, begin fetching at start_addr
//   redirect, redirect_addr    : in RUN, flush and refetch from redirect_addr
//   halt                       : stop issuing, deliver buffered words, go IDLE
//   rom_address, rom_q         : ROM address out, ROM data in (1-cycle latency)
//   instr_valid/data/pc, instr_ready : decoder handshake
//   busy                       : controller not in IDLE
module rom_fetch_unit
    import rom_fetch_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              halt,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_q,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready
    ,
    output logic              busy
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] tag_q, tag_d;
    logic              busy_q, busy_d;

    logic              pop_s;
    logic              push_s;
    logic              flush_s;
    logic              issue_s;
    logic              can_issue_s;

    assign pop_s = instr_valid && instr_ready;

`ifdef ROM_FETCH_SKID_EN
    fetch_entry_t push_entry_s;
    fetch_entry_t head_s;
    logic         head_valid_s;
    logic [1:0]   occ_s;
    logic [2:0]   slots_used_s;

    // Room check counts the word still in flight against the FIFO after this cycle's pop.
    always_comb begin
        push_entry_s.pc   = tag_q;
        push_entry_s.data = rom_q;
        slots_used_s      = {1'b0, occ_s} - {2'b00, pop_s} + {2'b00, inflight_q};
        can_issue_s       = (slots_used_s < 3'd2);
    end

    rom_fetch_skid u_skid (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush_s),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .head       (head_s),
        .head_valid (head_valid_s),
        .count      (occ_s)
    );

    assign instr_valid = head_valid_s;
    assign instr_data  = head_s.data;
    assign instr_pc    = head_s.pc;
`else
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;

    // Single output register: issue only when the returning word has a free slot.
    always_comb begin
        can_issue_s = !inflight_q && (!out_valid_q || instr_ready);
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_pc_d    = out_pc_q;
        if (flush_s) begin
            out_valid_d = 1'b0;
        end else if (push_s) begin
            out_valid_d = 1'b1;
            out_data_d  = rom_q;
            out_pc_d    = tag_q;
        end else if (pop_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output register.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= {DATA_W{1'b0}};
            out_pc_q    <= {ADDR_W{1'b0}};
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_pc_q    <= out_pc_d;
        end
    end

    assign instr_valid = out_valid_q;
    assign instr_data  = out_data_q;
    assign instr_pc    = out_pc_q;
`endif

    // Controller next-state: halt beats redirect; a redirect flush also drops the in-flight word.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        issue_s = 1'b0;
        flush_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = start_addr;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (halt) begin
                    state_d = ST_DRAIN;
                    flush_s = redirect;
                end else if (redirect) begin
                    pc_d    = redirect_addr;
                    flush_s = 1'b1;
                end else if (can_issue_s) begin
                    issue_s = 1'b1;
                    pc_d    = pc_inc(pc_q);
                end else begin
                    pc_d = pc_q;
                end
            end
            ST_DRAIN: begin
                if (!inflight_q && !instr_valid) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A read always returns the cycle after issue, so inflight lives exactly one cycle.
        inflight_d = issue_s;
        tag_d      = issue_s ? pc_q : tag_q;
        push_s     = inflight_q && !flush_s;
        busy_d     = (state_d != ST_IDLE);
    end

    // Controller registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= {ADDR_W{1'b0}};
            inflight_q <= 1'b0;
            tag_q      <= {ADDR_W{1'b0}};
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
            busy_q     <= busy_d;
        end
    end

    // The ROM address is the PC itself; re-reading a held address is harmless.
    assign rom_address = pc_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_rom_fetch_unit.sv
// tb_rom_fetch_unit: self-checking bench for rom_fetch_unit with a behavioural
// 256x16 ROM preloaded with mem[i] = 16'hA000 + i. Expected words go into a
// scoreboard queue when stimulus is driven and are popped on each handshake.
module tb_rom_fetch_unit;

`ifdef ROM_FETCH_SKID_EN
    localparam int STRIDE = 1;
    localparam int NBUF   = 2;
`else
    localparam int STRIDE = 2;
    localparam int NBUF   = 1;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  start_addr = 8'h00;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_addr = 8'h00;
    logic        halt = 1'b0;
    logic [7:0]  rom_address;
    logic [15:0] rom_q = 16'h0000;
    logic        instr_valid;
    logic [15:0] instr_data;
    logic [7:0]  instr_pc;
    logic        instr_ready = 1'b0;
    logic        busy;

    always #5 clock = ~clock;

    // Synchronous ROM: address sampled at the edge, word available the next cycle.
    always @(posedge clock) rom_q <= 16'hA000 + {8'h00, rom_address};

    rom_fetch_unit dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .start_addr    (start_addr),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .halt          (halt),
        .rom_address   (rom_address),
        .rom_q         (rom_q),
        .instr_valid   (instr_valid),
        .instr_data    (instr_data),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready),
        .busy          (busy)
    );

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        logic [7:0]  start_addr;
        int          n_words;
        logic [15:0] exp_first_data;
        logic [7:0]  exp_last_pc;
    } vec_t;

    exp_t       sb_q[$];
    vec_t       vecs[4];
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] last_acc_pc = 8'h00;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic void sb_push(input logic [7:0] pc);
        exp_t e;
        e.pc   = pc;
        e.data = 16'hA000 + {8'h00, pc};
        sb_q.push_back(e);
    endfunction

    // One clock: drive ready, score a handshake that completes at the coming edge.
    task automatic cycle(input logic rdy);
        exp_t e;
        instr_ready = rdy;
        if (instr_valid && rdy) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word actual_pc=%0h data=%0h required=none", instr_pc, instr_data);
            end else begin
                e = sb_q.pop_front();
                check("sb_pc", {24'h0, instr_pc}, {24'h0, e.pc});
                check("sb_data", {16'h0, instr_data}, {16'h0, e.data});
                last_acc_pc = instr_pc;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic [7:0] addr);
        start_addr = addr;
        start      = 1'b1;
        cycle(1'b0);
        start      = 1'b0;
        check("start_busy", {31'h0, busy}, 32'd1);
        check("start_pc", {24'h0, rom_address}, {24'h0, addr});
    endtask

    task automatic wait_valid(input int exp_lat, input string name, input logic rdy);
        int n = 0;
        while (!instr_valid && n < 12) begin
            cycle(rdy);
            n++;
        end
        check(name, n, exp_lat);
    endtask

    task automatic drain_sb(input int exp_iters, input string name);
        int n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            cycle(1'b1);
            n++;
        end
        check(name, n, exp_iters);
    endtask

    task automatic wait_idle(input int exp_n, input string name, input logic rdy);
        int n = 0;
        while (busy && n < 10) begin
            cycle(rdy);
            n++;
        end
        check(name, n, exp_n);
    endtask

    // Close a run with halt+redirect: everything is flushed and the unit returns to IDLE.
    task automatic end_run();
        halt          = 1'b1;
        redirect      = 1'b1;
        redirect_addr = 8'hC0;
        cycle(1'b0);
        halt     = 1'b0;
        redirect = 1'b0;
        check("flush_valid", {31'h0, instr_valid}, 32'd0);
        wait_idle(1, "flush_idle", 1'b0);
        check("sb_leftover", sb_q.size(), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h00, 3, 16'hA000, 8'h02};
        vecs[1] = '{8'hFE, 4, 16'hA0FE, 8'h01};
        vecs[2] = '{8'h7F, 5, 16'hA07F, 8'h83};
        vecs[3] = '{8'hFF, 2, 16'hA0FF, 8'h00};

        // Reset state
        cycle(1'b0);
        cycle(1'b0);
        reset = 1'b0;
        cycle(1'b0);
        check("rst_rom_address", {24'h0, rom_address}, 32'd0);
        check("rst_valid", {31'h0, instr_valid}, 32'd0);
        check("rst_data", {16'h0, instr_data}, 32'd0);
        check("rst_pc", {24'h0, instr_pc}, 32'd0);
        check("rst_busy", {31'h0, busy}, 32'd0);

        // Table-driven sequential fetch runs, including the 0xFF -> 0x00 wrap
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < vecs[i].n_words; j++) begin
                logic [7:0] p;
                p = vecs[i].start_addr + 8'(j);
                sb_push(p);
            end
            do_start(vecs[i].start_addr);
            wait_valid(2, "tbl_latency", 1'b1);
            check("tbl_first_data", {16'h0, instr_data}, {16'h0, vecs[i].exp_first_data});
            drain_sb((vecs[i].n_words - 1) * STRIDE + 1, "tbl_span");
            check("tbl_last_pc", {24'h0, last_acc_pc}, {24'h0, vecs[i].exp_last_pc});
            end_run();
        end

        // Back-pressure: first word held stable for 5 cycles, then sequence resumes
        sb_push(8'h00);
        sb_push(8'h01);
        sb_push(8'h02);
        do_start(8'h00);
        wait_valid(2, "stall_latency", 1'b0);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0);
            check("stall_valid", {31'h0, instr_valid}, 32'd1);
            check("stall_data", {16'h0, instr_data}, 32'hA000);
            check("stall_pc", {24'h0, instr_pc}, 32'd0);
        end
        drain_sb(2 * STRIDE + 1, "stall_resume");
        end_run();

        // Redirect to 0x40 while word 0x05 is in flight
        do_start(8'h05);
        cycle(1'b1);
        redirect      = 1'b1;
        redirect_addr = 8'h40;
        sb_push(8'h40);
        sb_push(8'h41);
        cycle(1'b1);
        redirect = 1'b0;
        check("redir_flush_valid", {31'h0, instr_valid}, 32'd0);
        wait_valid(2, "redir_latency", 1'b1);
        check("redir_first_pc", {24'h0, instr_pc}, 32'h40);
        drain_sb(STRIDE + 1, "redir_span");
        end_run();

        // Halt with the output buffer full: buffered words delivered, then IDLE
        do_start(8'h10);
        wait_valid(2, "halt_latency", 1'b0);
        cycle(1'b0);
        cycle(1'b0);
        cycle(1'b0);
        for (int k = 0; k < NBUF; k++) begin
            logic [7:0] p;
            p = 8'h10 + 8'(k);
            sb_push(p);
        end
        halt = 1'b1;
        cycle(1'b1);
        halt = 1'b0;
        drain_sb(NBUF - 1, "halt_drain");
        wait_idle(1, "halt_idle", 1'b1);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1);
            check("halt_quiet", {31'h0, instr_valid}, 32'd0);
        end

        // Halt and redirect together with a word in flight: nothing delivered, pc not redirected
        do_start(8'h20);
        cycle(1'b1);
        halt          = 1'b1;
        redirect      = 1'b1;
        redirect_addr = 8'h40;
        cycle(1'b1);
        halt     = 1'b0;
        redirect = 1'b0;
        check("hr_valid", {31'h0, instr_valid}, 32'd0);
        wait_idle(1, "hr_idle", 1'b1);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1);
            check("hr_quiet", {31'h0, instr_valid}, 32'd0);
        end
        check("hr_pc_kept", {24'h0, rom_address}, 32'h21);

        // Reset mid-run with a word presented, then a fresh start
        do_start(8'h30);
        wait_valid(2, "mid_latency", 1'b0);
        reset = 1'b1;
        cycle(1'b0);
        reset = 1'b0;
        check("mid_rst_rom_address", {24'h0, rom_address}, 32'd0);
        check("mid_rst_valid", {31'h0, instr_valid}, 32'd0);
        check("mid_rst_data", {16'h0, instr_data}, 32'd0);
        check("mid_rst_pc", {24'h0, instr_pc}, 32'd0);
        check("mid_rst_busy", {31'h0, busy}, 32'd0);
        sb_push(8'h50);
        sb_push(8'h51);
        do_start(8'h50);
        wait_valid(2, "post_rst_latency", 1'b1);
        drain_sb(STRIDE + 1, "post_rst_span");
        end_run();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
